// File: rtl/i2c_reg_seq_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared types for the i2c_reg_seq register-access sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_W_CMD       = 4'd1,
    ST_W_DATA      = 4'd2,
    ST_R_CMD_ADDR  = 4'd3,
    ST_R_DATA_ADDR = 4'd4,
    ST_R_CMD_RD    = 4'd5,
    ST_R_WAIT      = 4'd6,
    ST_ABORT       = 4'd7,
    ST_RESP        = 4'd8
  } state_e;

  typedef struct packed {
    logic [6:0] address;
    logic       start;
    logic       read;
    logic       write;
    logic       write_multiple;
    logic       stop;
  } cmd_t;

  localparam cmd_t C_CMD_STOP_ONLY = '{address: 7'd0, start: 1'b0, read: 1'b0,
                                       write: 1'b0, write_multiple: 1'b0, stop: 1'b1};

endpackage

`default_nettype wire

// File: rtl/i2c_reg_seq.sv
// ============================================================================
// Module : i2c_reg_seq
// Brief  : Sequences single-register I2C reads/writes onto an i2c_master.
//          Optional macro I2C_REG_SEQ_TIMEOUT_EN adds a per-transaction timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_reg_seq
  import i2c_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic       req_read,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_timeout,
  output logic [6:0] m_cmd_address,
  output logic       m_cmd_start,
  output logic       m_cmd_read,
  output logic       m_cmd_write,
  output logic       m_cmd_write_multiple,
  output logic       m_cmd_stop,
  output logic       m_cmd_valid,
  input  logic       m_cmd_ready,
  output logic [7:0] m_wr_tdata,
  output logic       m_wr_tvalid,
  output logic       m_wr_tlast,
  input  logic       m_wr_tready,
  input  logic [7:0] s_rd_tdata,
  input  logic       s_rd_tvalid,
  input  logic       s_rd_tlast,
  output logic       s_rd_tready,
  input  logic       missed_ack,
  input  logic       bus_busy
);

  state_e     r_state;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [7:0] r_wdata;
  cmd_t       r_cmd;
  logic       r_cmd_valid;
  logic [7:0] r_wr_data;
  logic       r_wr_valid;
  logic       r_wr_last;
  logic [7:0] r_rdata;
  logic       r_nack;

  logic w_cmd_hs;
  logic w_wr_hs;
  logic w_accept;
  logic w_active;
  logic w_expire;
  logic w_unused;

  assign w_cmd_hs = r_cmd_valid & m_cmd_ready;
  assign w_wr_hs  = r_wr_valid & m_wr_tready;
  assign w_accept = req_valid & req_ready;
  // Bus-driving states: where a NACK or timeout can cut the transaction short.
  assign w_active = (r_state != ST_IDLE) && (r_state != ST_RESP) && (r_state != ST_ABORT);
  assign w_unused = ^{s_rd_tlast, TIMEOUT_CYCLES};

`ifdef I2C_REG_SEQ_TIMEOUT_EN
  logic [31:0] r_timer;
  logic        r_timeout;

  assign w_expire    = w_active && (r_timer == 32'd0);
  assign rsp_timeout = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer   <= 32'd0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_timer   <= TIMEOUT_CYCLES;
      r_timeout <= 1'b0;
    end else if (w_active && r_timer != 32'd0) begin
      r_timer <= r_timer - 32'd1;
    end else if (w_expire && !missed_ack) begin
      r_timeout <= 1'b1;
    end
  end
`else
  assign w_expire    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_dev       <= 7'd0;
      r_reg       <= 8'd0;
      r_wdata     <= 8'd0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_wr_data   <= 8'd0;
      r_wr_valid  <= 1'b0;
      r_wr_last   <= 1'b0;
      r_rdata     <= 8'd0;
      r_nack      <= 1'b0;
    end else if (w_active && (missed_ack || w_expire)) begin
      // NACK wins over any handshake completing on the same edge.
      r_cmd_valid <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_nack      <= r_nack | missed_ack;
      r_rdata     <= 8'd0;
      r_state     <= ST_ABORT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dev       <= req_dev_addr;
            r_reg       <= req_reg_addr;
            r_wdata     <= req_wdata;
            r_nack      <= 1'b0;
            r_rdata     <= 8'd0;
            r_cmd_valid <= 1'b1;
            if (req_read) begin
              r_cmd   <= '{address: req_dev_addr, start: 1'b1, read: 1'b0, write: 1'b1,
                           write_multiple: 1'b0, stop: 1'b0};
              r_state <= ST_R_CMD_ADDR;
            end else begin
              r_cmd   <= '{address: req_dev_addr, start: 1'b1, read: 1'b0, write: 1'b0,
                           write_multiple: 1'b1, stop: 1'b1};
              r_state <= ST_W_CMD;
            end
          end
        end
        ST_W_CMD: begin
          if (w_cmd_hs) begin
            r_cmd_valid <= 1'b0;
            r_wr_data   <= r_reg;
            r_wr_last   <= 1'b0;
            r_wr_valid  <= 1'b1;
            r_state     <= ST_W_DATA;
          end
        end
        ST_W_DATA: begin
          if (w_wr_hs) begin
            if (!r_wr_last) begin
              r_wr_data <= r_wdata;
              r_wr_last <= 1'b1;
            end else begin
              r_wr_valid <= 1'b0;
              r_state    <= ST_RESP;
            end
          end
        end
        ST_R_CMD_ADDR: begin
          if (w_cmd_hs) begin
            r_cmd_valid <= 1'b0;
            r_wr_data   <= r_reg;
            r_wr_last   <= 1'b1;
            r_wr_valid  <= 1'b1;
            r_state     <= ST_R_DATA_ADDR;
          end
        end
        ST_R_DATA_ADDR: begin
          if (w_wr_hs) begin
            r_wr_valid  <= 1'b0;
            r_cmd       <= '{address: r_dev, start: 1'b1, read: 1'b1, write: 1'b0,
                             write_multiple: 1'b0, stop: 1'b1};
            r_cmd_valid <= 1'b1;
            r_state     <= ST_R_CMD_RD;
          end
        end
        ST_R_CMD_RD: begin
          if (w_cmd_hs) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_R_WAIT;
          end
        end
        ST_R_WAIT: begin
          if (s_rd_tvalid) begin
            r_rdata <= s_rd_tdata;
            r_state <= ST_RESP;
          end
        end
        ST_ABORT: begin
          // An idle bus needs no stop; otherwise release it before responding.
          if (r_cmd_valid) begin
            if (w_cmd_hs) begin
              r_cmd_valid <= 1'b0;
              r_state     <= ST_RESP;
            end
          end else if (!bus_busy) begin
            r_state <= ST_RESP;
          end else begin
            r_cmd       <= C_CMD_STOP_ONLY;
            r_cmd_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready            = (r_state == ST_IDLE) && !rsp_valid;
  assign rsp_valid            = (r_state == ST_RESP);
  assign rsp_rdata            = r_rdata;
  assign rsp_nack             = r_nack;
  assign m_cmd_address        = r_cmd.address;
  assign m_cmd_start          = r_cmd.start;
  assign m_cmd_read           = r_cmd.read;
  assign m_cmd_write          = r_cmd.write;
  assign m_cmd_write_multiple = r_cmd.write_multiple;
  assign m_cmd_stop           = r_cmd.stop;
  assign m_cmd_valid          = r_cmd_valid;
  assign m_wr_tdata           = r_wr_data;
  assign m_wr_tvalid          = r_wr_valid;
  assign m_wr_tlast           = r_wr_last;
  assign s_rd_tready          = (r_state == ST_R_WAIT);

endmodule

`default_nettype wire
